instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage of the LEGv8 datapath, directly upstream of the main controller. It holds the program counter and issues word requests to instruction memory over a grant/valid handshake, with one request outstanding at most. It buffers the returned word in a one-entry output register for decode and accepts branch redirects from execute. It also presents the 11-bit opcode field, Instruction[31:21], that the controller decodes.

## Interface
- ADDR_W, 64, width of PC and instruction-memory address.
- RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ImemReq  out  1  fetch request valid.
- ImemAddr  out  ADDR_W  fetch address, always equal to PC.
- ImemGnt  in  1  memory accepts request this cycle; handshake completes when ImemReq && ImemGnt.
- ImemRvalid  in  1  read data valid; arrives 1 or more cycles after handshake.
- ImemRdata  in  32  instruction word.
- InstrValid  out  1  output register holds a valid instruction.
- InstrReady  in  1  decode consumes the instruction; transfer completes when InstrValid && InstrReady.
- Instruction  out  32  buffered instruction word.
- InstrPC  out  ADDR_W  address the buffered word was fetched from.
- Opcode  out  11  Instruction[31:21] when InstrValid=1, else 11'b0. The all-zero value is the controller's no-op decode.
- BranchTaken  in  1  single-cycle redirect pulse from execute.
- BranchTarget  in  ADDR_W  redirect address. Bits [1:0] are ignored and forced to 0.

## Operation
- States: FETCH, WAIT, DRAIN.
- Slot free: the output register is free when InstrValid=0, or when InstrValid && InstrReady in the same cycle.
- Request condition, combinational: ImemReq = (state==FETCH) && slot free && !BranchTaken.
- FETCH:
  - On handshake: latch ReqPC <= PC, PC <= PC+4, go to WAIT.
  - With no grant, ImemReq stays high and ImemAddr stays stable.
- WAIT:
  - On ImemRvalid: Instruction <= ImemRdata, InstrPC <= ReqPC, InstrValid <= 1, go to FETCH.
  - The output slot is always free here, because only one request is ever outstanding.
- DRAIN:
  - On ImemRvalid: discard the data, go to FETCH.
  - InstrValid stays 0.
- Redirect (BranchTaken=1) has priority over every other event in the same cycle:
  - PC <= {BranchTarget[ADDR_W-1:2], 2'b00}.
  - InstrValid <= 0. An unaccepted instruction is dropped.
  - If a transfer to decode completes in the same cycle, it still counts as delivered.
  - FETCH → FETCH. No request is issued that cycle.
  - WAIT → DRAIN.
  - DRAIN → DRAIN, with the new PC.
  - WAIT with ImemRvalid in the same cycle: the data is discarded, go to FETCH.
- Output-register transfer: when InstrValid && InstrReady with no new load, InstrValid <= 0.
- ImemRvalid is ignored in FETCH; it is treated as stale.
- PC increments wrap modulo 2^ADDR_W.

## Timing
- Reset, asynchronous:
  - PC=RESET_PC, state=FETCH.
  - ImemReq=0, InstrValid=0, Instruction=0, InstrPC=0, Opcode=0.
  - ImemAddr=RESET_PC.
- Assertion mid-operation aborts any outstanding request. The memory side is reset by the same rst_n.
- First ImemReq is high in the first cycle after rst_n deasserts, with ImemAddr=RESET_PC.
- Latency:
  - Handshake at cycle t, ImemRvalid at cycle t+L (L≥1).
  - InstrValid is high from cycle t+L+1.
  - Next ImemReq can be high at t+L+1 if decode accepts.
- Throughput with L=1 and InstrReady held high: one instruction every 2 cycles.
- Redirect at cycle t: ImemAddr=target from cycle t+1, and ImemReq is high at t+1 if state is FETCH.
- Outputs Instruction, InstrPC and Opcode are registered, or derived from registers. They stay stable while InstrValid && !InstrReady.

## Test plan
- Reset: hold rst_n=0 mid-fetch → all outputs 0 immediately. Release with RESET_PC=0 → ImemReq=1, ImemAddr=0x0 on the first cycle.
- Sequential fetch:
  - Setup: L=1, InstrReady=1, memory returns 0xF8400000 at address 0 and 0x8B020020 at address 4.
  - Required: InstrValid with InstrPC=0 and Opcode=11'b11111000010, then InstrPC=4 and Opcode=11'b10001011000.
  - Required: ImemAddr steps 0, 4, 8, with one instruction every 2 cycles.
- Backpressure: InstrReady=0 for 5 cycles with a word buffered → Instruction and InstrPC stable, ImemReq=0. Raise InstrReady → ImemReq high in the same cycle.
- Grant stall: ImemGnt=0 for 3 cycles → ImemReq stays 1, ImemAddr stays 0x8, PC does not advance.
- Redirect in WAIT:
  - Stimulus: BranchTaken with target 0x103 while a request is outstanding, L=3.
  - Required: the returned word is dropped and InstrValid stays 0.
  - Required: the next ImemAddr is 0x100, and the first delivered InstrPC is 0x100.
- Redirect versus buffered instruction: InstrValid=1, InstrReady=0, BranchTaken=1 → InstrValid=0 and Opcode=0 next cycle, then fetch from the target. Repeat with BranchTaken coinciding with ImemRvalid in WAIT → data discarded, state FETCH.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit : LEGv8 fetch stage, one outstanding imem request,
//                    one-entry decode buffer, branch redirect from execute.
// Revision: 1.0
// ============================================================================
module instr_fetch_unit #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ImemReq,
    output logic [ADDR_W-1:0] ImemAddr,
    input  logic              ImemGnt,
    input  logic              ImemRvalid,
    input  logic [31:0]       ImemRdata,
    output logic              InstrValid,
    input  logic              InstrReady,
    output logic [31:0]       Instruction,
    output logic [ADDR_W-1:0] InstrPC,
    output logic [10:0]       Opcode,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_instr_pc;

    logic              w_slot_free;
    logic              w_handshake;
    logic              w_transfer;
    logic [ADDR_W-1:0] w_branch_pc;

    assign w_slot_free = !r_valid || InstrReady;
    assign w_transfer  = r_valid && InstrReady;
    assign w_branch_pc = {BranchTarget[ADDR_W-1:2], 2'b00};

    // Gated by rst_n so the request line is low while reset is held.
    assign ImemReq     = rst_n && (r_state == FETCH) && w_slot_free && !BranchTaken;
    assign w_handshake = ImemReq && ImemGnt;

    assign ImemAddr    = r_pc;
    assign InstrValid  = r_valid;
    assign Instruction = r_instr;
    assign InstrPC     = r_instr_pc;
    assign Opcode      = r_valid ? r_instr[31:21] : 11'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else if (BranchTaken) begin
            r_pc    <= w_branch_pc;
            r_valid <= 1'b0;
            // A response landing in the redirect cycle closes the outstanding
            // request, so there is nothing left to drain.
            case (r_state)
                WAIT, DRAIN: r_state <= ImemRvalid ? FETCH : DRAIN;
                default:     r_state <= FETCH;
            endcase
        end else begin
            if (w_transfer) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                FETCH: begin
                    if (w_handshake) begin
                        r_req_pc <= r_pc;
                        r_pc     <= r_pc + ADDR_W'(4);
                        r_state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (ImemRvalid) begin
                        r_instr    <= ImemRdata;
                        r_instr_pc <= r_req_pc;
                        r_valid    <= 1'b1;
                        r_state    <= FETCH;
                    end
                end
                DRAIN: begin
                    if (ImemRvalid) begin
                        r_state <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch_unit : scoreboard bench with randomized memory/decode/branch.
// Revision: 1.0
// ============================================================================
module tb_instr_fetch_unit;

    localparam int AW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ImemReq;
    logic [AW-1:0] ImemAddr;
    logic          ImemGnt = 1'b0;
    logic          ImemRvalid = 1'b0;
    logic [31:0]   ImemRdata = '0;
    logic          InstrValid;
    logic          InstrReady = 1'b0;
    logic [31:0]   Instruction;
    logic [AW-1:0] InstrPC;
    logic [10:0]   Opcode;
    logic          BranchTaken = 1'b0;
    logic [AW-1:0] BranchTarget = '0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(AW), .RESET_PC('0)) dut (
        .clk(clk), .rst_n(rst_n),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt),
        .ImemRvalid(ImemRvalid), .ImemRdata(ImemRdata),
        .InstrValid(InstrValid), .InstrReady(InstrReady),
        .Instruction(Instruction), .InstrPC(InstrPC), .Opcode(Opcode),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget)
    );

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [31:0]   word;
    } entry_t;

    int     checks = 0;
    int     errors = 0;
    entry_t exp_q[$];

    // Architectural model: next fetch address, one outstanding request, one slot.
    logic [AW-1:0] m_pc, m_req_addr;
    bit            m_out, m_killed, m_slot;

    // Memory emulation.
    bit            mem_busy;
    int            mem_cnt;
    logic [AW-1:0] mem_addr;

    int            p_gnt = 100, p_ready = 100, p_branch = 0;
    int            lat_min = 1, lat_max = 1, br_mode = 0;
    logic [AW-1:0] br_target = '0;

    function automatic logic [31:0] mem_word(logic [AW-1:0] a);
        if (a == 0) return 32'hF840_0000;
        if (a == 4) return 32'h8B02_0020;
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        bit rv, br, pred_req;
        @(negedge clk);
        rv = 1'b0;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt <= 0) begin
                rv = 1'b1;
                mem_busy = 1'b0;
            end
        end
        ImemRvalid   = rv;
        ImemRdata    = rv ? mem_word(mem_addr) : 32'($urandom);
        ImemGnt      = ($urandom_range(99) < p_gnt);
        InstrReady   = ($urandom_range(99) < p_ready);
        br           = ($urandom_range(99) < p_branch);
        BranchTarget = AW'($urandom_range(0, 32'hFFF));
        case (br_mode)
            1: br = 1'b1;
            2: br = m_out && !rv;
            3: br = rv;
            4: begin br = m_slot; if (m_slot) InstrReady = 1'b0; end
            default: ;
        endcase
        if (br_mode != 0 && br) begin
            BranchTarget = br_target;
            br_mode = 0;
        end
        BranchTaken = br;
        #2;
        pred_req = !m_out && (!m_slot || InstrReady) && !br;
        chk("imem_req", AW'(ImemReq), AW'(pred_req));
        if (pred_req) chk("imem_addr", ImemAddr, m_pc);
        chk("instr_valid", AW'(InstrValid), AW'(m_slot));
        if (ImemReq && ImemGnt) begin
            mem_busy = 1'b1;
            mem_addr = ImemAddr;
            mem_cnt  = $urandom_range(lat_min, lat_max);
        end
        if (br) begin
            if (m_slot && !InstrReady && exp_q.size() > 0) void'(exp_q.pop_front());
            m_slot = 1'b0;
            m_pc   = (BranchTarget >> 2) << 2;
            if (m_out) begin
                if (rv) m_out = 1'b0;
                else    m_killed = 1'b1;
            end
        end else begin
            if (m_slot && InstrReady) m_slot = 1'b0;
            if (pred_req && ImemGnt) begin
                m_out      = 1'b1;
                m_killed   = 1'b0;
                m_req_addr = m_pc;
                m_pc       = m_pc + 4;
            end else if (m_out && rv) begin
                m_out = 1'b0;
                if (!m_killed) begin
                    exp_q.push_back('{pc: m_req_addr, word: mem_word(m_req_addr)});
                    m_slot = 1'b1;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_imem_req", AW'(ImemReq), '0);
        chk("rst_instr_valid", AW'(InstrValid), '0);
        chk("rst_instruction", AW'(Instruction), '0);
        chk("rst_instr_pc", InstrPC, '0);
        chk("rst_opcode", AW'(Opcode), '0);
        chk("rst_imem_addr", ImemAddr, '0);
        exp_q.delete();
        m_pc = '0; m_out = 0; m_killed = 0; m_slot = 0;
        mem_busy = 0; mem_cnt = 0;
        ImemRvalid = 0; ImemGnt = 0; BranchTaken = 0; InstrReady = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_req", AW'(ImemReq), AW'(1));
        chk("first_addr", ImemAddr, '0);
    endtask

    task automatic wait_mode_done(input string name);
        for (int i = 0; i < 40 && br_mode != 0; i++) cycle();
        if (br_mode != 0) begin
            checks++; errors++;
            $display("FAIL %s actual=not_triggered required=triggered", name);
            br_mode = 0;
        end
    endtask

    // Monitor: compares the presented instruction against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (InstrValid) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_instr actual=%0h required=none", InstrPC);
                    end else begin
                        chk("instr_pc", InstrPC, exp_q[0].pc);
                        chk("instruction", AW'(Instruction), AW'(exp_q[0].word));
                        chk("opcode", AW'(Opcode), AW'(exp_q[0].word[31:21]));
                        if (InstrReady) void'(exp_q.pop_front());
                    end
                end else begin
                    chk("opcode_idle", AW'(Opcode), '0);
                end
            end
        end
    end

    initial begin
        do_reset();

        // Straight-line fetch, L=1, decode always ready.
        p_gnt = 100; p_ready = 100; lat_min = 1; lat_max = 1;
        repeat (10) cycle();

        // Backpressure then release.
        p_ready = 0;
        repeat (6) cycle();
        p_ready = 100;
        repeat (3) cycle();

        // Grant stall.
        p_gnt = 0;
        repeat (3) cycle();
        p_gnt = 100;
        repeat (4) cycle();

        // Redirect while a request is outstanding, L=3.
        lat_min = 3; lat_max = 3;
        br_target = AW'(32'h103); br_mode = 2;
        wait_mode_done("redirect_wait");
        repeat (10) cycle();

        // Redirect against a buffered, unaccepted instruction.
        lat_min = 1; lat_max = 1;
        br_target = AW'(32'h200); br_mode = 4;
        wait_mode_done("redirect_buffered");
        repeat (6) cycle();

        // Redirect coinciding with the returning word.
        lat_min = 2; lat_max = 2;
        br_target = AW'(32'h300); br_mode = 3;
        wait_mode_done("redirect_rvalid");
        repeat (6) cycle();

        // PC wraps past the top of the address space.
        br_target = {AW{1'b1}} - AW'(2); br_mode = 1;
        wait_mode_done("redirect_wrap");
        repeat (8) cycle();

        // Reset while a request is outstanding.
        lat_min = 4; lat_max = 4;
        for (int i = 0; i < 20 && !m_out; i++) cycle();
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (6) cycle();

        // Randomized traffic.
        for (int blk = 0; blk < 15; blk++) begin
            p_gnt    = $urandom_range(30, 100);
            p_ready  = $urandom_range(20, 100);
            p_branch = $urandom_range(0, 10);
            lat_min  = $urandom_range(1, 2);
            lat_max  = $urandom_range(lat_min, 4);
            repeat (200) cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
